// File: rtl/uart_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam logic [31:0] UART_DATA_OFS = 32'd0;
  localparam logic [31:0] UART_STAT_OFS = 32'd4;

  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; storage is not reset, only pointers and count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/mmio_uart_tx.sv
// Store-port UART transmitter: address decode, status register, TX FIFO and 8N1 serialiser.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        rd_hit,
  output logic        tx,
  output logic        busy
);

  localparam int            BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic          data_sel, stat_sel, data_wr, stat_wr;
  logic          push, pop, full, empty, overflow;
  logic [7:0]    head, shift, shift_n;
  tx_state_t     state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic          tx_q, tx_n;
  logic          unused_bits;

  assign data_sel    = (DataAdr == BASE_ADDR + UART_DATA_OFS);
  assign stat_sel    = (DataAdr == BASE_ADDR + UART_STAT_OFS);
  assign rd_hit      = data_sel | stat_sel;
  assign data_wr     = MemWrite & data_sel;
  assign stat_wr     = MemWrite & stat_sel;
  assign unused_bits = ^WriteData[31:8];

  // A push into a full FIFO still lands when the serialiser pops the same cycle.
  assign push = data_wr & (~full | pop);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (WriteData[7:0]),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (reset)                             overflow <= 1'b0;
    else if (data_wr && !push)             overflow <= 1'b1;
    else if (stat_wr && WriteData[ST_OVF]) overflow <= 1'b0;
  end

  assign busy = ~empty | (state != IDLE);

  always_comb begin
    ReadData = '0;
    if (stat_sel) begin
      ReadData[ST_BUSY]  = busy;
      ReadData[ST_FULL]  = full;
      ReadData[ST_EMPTY] = empty;
      ReadData[ST_OVF]   = overflow;
    end
  end

  always_comb begin
    state_n   = state;
    baud_n    = baud + BW'(1);
    bit_idx_n = bit_idx;
    shift_n   = shift;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        baud_n = '0;
        if (!empty) begin
          pop       = 1'b1;
          shift_n   = head;
          bit_idx_n = '0;
          state_n   = START;
        end
      end
      START: if (baud == BAUD_LAST) begin
        baud_n  = '0;
        state_n = DATA;
      end
      DATA: if (baud == BAUD_LAST) begin
        baud_n = '0;
        if (bit_idx == 3'd7) begin
          state_n = STOP;
        end else begin
          shift_n   = shift >> 1;
          bit_idx_n = bit_idx + 3'd1;
        end
      end
      STOP: if (baud == BAUD_LAST) begin
        baud_n  = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Line level is decided from the next state so the output flop changes with the state.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      tx_q    <= tx_n;
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_n;
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench: a line decoder turns tx back into 8N1 frames and compares them with written bytes.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'h0000_0400;
  localparam int          CPB   = 16;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        rd_hit, tx, busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [9:0] frames_q[$];
  int         starts_q[$];

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .rd_hit    (rd_hit),
    .tx        (tx),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Line decoder: on a falling edge, sample each bit at its centre; a reset abandons the frame.
  initial begin
    logic [9:0] bits;
    logic       aborted;
    logic       prev;
    int         start_c;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (tx === 1'b0 && prev === 1'b1 && reset === 1'b0) begin
        bits    = '0;
        aborted = 1'b0;
        start_c = cyc;
        for (int c = 1; c < FRAME; c++) begin
          @(negedge clk);
          if (reset === 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (c % CPB == CPB / 2) bits[c / CPB] = tx;
        end
        if (!aborted) begin
          frames_q.push_back(bits);
          starts_q.push_back(start_c);
        end
      end
      prev = tx;
    end
  end

  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  // Called at a negedge; drives one store that is sampled by the following posedge.
  task automatic write(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    @(negedge clk);
    MemWrite  = 1'b0;
    DataAdr   = '0;
  endtask

  task automatic wait_idle(input int bound, output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < bound) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    DataAdr = BASE + 4;
    #1;
    n_checks++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (ReadData !== 32'h4) $display("FAIL reset_status: got %h want 00000004", ReadData); else n_pass++;
    n_checks++; if (rd_hit !== 1'b1) $display("FAIL reset_rd_hit: got %b want 1", rd_hit); else n_pass++;
    DataAdr = '0;
  endtask

  task automatic test_single;
    int cnt;
    frames_q.delete();
    starts_q.delete();
    write(BASE, 32'hA5);
    n_checks++; if (tx !== 1'b1) $display("FAIL single_pre_pop_tx: got %b want 1", tx); else n_pass++;
    @(negedge clk);
    n_checks++; if (tx !== 1'b0) $display("FAIL single_latency_tx: got %b want 0", tx); else n_pass++;
    wait_idle(FRAME + 40, cnt);
    n_checks++; if (cnt !== FRAME) $display("FAIL single_busy_len: got %0d want %0d", cnt, FRAME); else n_pass++;
    n_checks++; if (frames_q.size() !== 1) $display("FAIL single_frame_count: got %0d want 1", frames_q.size());
    else begin
      n_pass++;
      n_checks++; if (frames_q[0] !== 10'h34A) $display("FAIL single_frame_bits: got %h want 34a", frames_q[0]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    int cnt;
    frames_q.delete();
    starts_q.delete();
    write(BASE, 32'h01);
    write(BASE, 32'h80);
    wait_idle(3 * FRAME, cnt);
    n_checks++; if (cnt !== 2 * FRAME + 1) $display("FAIL b2b_busy_len: got %0d want %0d", cnt, 2 * FRAME + 1); else n_pass++;
    n_checks++; if (frames_q.size() !== 2) $display("FAIL b2b_frame_count: got %0d want 2", frames_q.size());
    else begin
      n_pass++;
      n_checks++; if (starts_q[1] - starts_q[0] !== FRAME + 1) $display("FAIL b2b_gap: got %0d want %0d", starts_q[1] - starts_q[0], FRAME + 1); else n_pass++;
      n_checks++; if (frames_q[0] !== frame_of(8'h01)) $display("FAIL b2b_frame0: got %h want %h", frames_q[0], frame_of(8'h01)); else n_pass++;
      n_checks++; if (frames_q[1] !== frame_of(8'h80)) $display("FAIL b2b_frame1: got %h want %h", frames_q[1], frame_of(8'h80)); else n_pass++;
    end
  endtask

  task automatic test_random;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int         cnt, polls;
    frames_q.delete();
    starts_q.delete();
    for (int i = 0; i < 7; i++) begin
      DataAdr = BASE + 4;
      polls   = 0;
      #1;
      while (ReadData[1] === 1'b1 && polls < 4 * FRAME) begin
        @(negedge clk);
        polls++;
        #1;
      end
      b = 8'($urandom);
      exp_q.push_back(b);
      write(BASE, {24'h0, b});
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    wait_idle(10 * FRAME, cnt);
    n_checks++; if (busy !== 1'b0) $display("FAIL random_idle: got busy %b want 0", busy); else n_pass++;
    n_checks++; if (frames_q.size() !== exp_q.size()) $display("FAIL random_frame_count: got %0d want %0d", frames_q.size(), exp_q.size());
    else begin
      n_pass++;
      foreach (exp_q[i]) begin
        n_checks++;
        if (frames_q[i] !== frame_of(exp_q[i])) $display("FAIL random_frame%0d: got %h want %h", i, frames_q[i], frame_of(exp_q[i]));
        else n_pass++;
      end
    end
    DataAdr = BASE + 4;
    #1;
    n_checks++; if (ReadData !== 32'h4) $display("FAIL random_status_end: got %h want 00000004", ReadData); else n_pass++;
    DataAdr = '0;
  endtask

  task automatic test_overflow;
    logic [7:0] bytes_q[$];
    int         cnt;
    int         n_keep;
    frames_q.delete();
    starts_q.delete();
    for (int i = 0; i < DEPTH + 2; i++) bytes_q.push_back(8'($urandom));
    foreach (bytes_q[i]) write(BASE, {24'h0, bytes_q[i]});
    // One byte leaves for the serialiser at once, DEPTH more fit; the rest are dropped.
    n_keep  = DEPTH + 1;
    DataAdr = BASE + 4;
    #1;
    n_checks++; if (ReadData !== 32'hB) $display("FAIL ovf_status_set: got %h want 0000000b", ReadData); else n_pass++;
    write(BASE + 4, 32'h8);
    DataAdr = BASE + 4;
    #1;
    n_checks++; if (ReadData !== 32'h3) $display("FAIL ovf_status_clear: got %h want 00000003", ReadData); else n_pass++;
    DataAdr = '0;
    wait_idle(8 * FRAME, cnt);
    n_checks++; if (frames_q.size() !== n_keep) $display("FAIL ovf_frame_count: got %0d want %0d", frames_q.size(), n_keep);
    else begin
      n_pass++;
      for (int i = 0; i < n_keep; i++) begin
        n_checks++;
        if (frames_q[i] !== frame_of(bytes_q[i])) $display("FAIL ovf_frame%0d: got %h want %h", i, frames_q[i], frame_of(bytes_q[i]));
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] b0;
    int         lows;
    frames_q.delete();
    starts_q.delete();
    b0 = 8'($urandom);
    write(BASE, {24'h0, b0});
    write(BASE, {24'h0, 8'($urandom)});
    write(BASE, {24'h0, 8'($urandom)});
    // Now one negedge past the start edge; move to the centre of data bit 3.
    repeat (CPB + 3 * CPB + CPB / 2 - 1) @(negedge clk);
    n_checks++; if (tx !== b0[3]) $display("FAIL midframe_bit3: got %b want %b", tx, b0[3]); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    DataAdr = BASE + 4;
    #1;
    n_checks++; if (tx !== 1'b1) $display("FAIL midframe_reset_tx: got %b want 1", tx); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL midframe_reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (ReadData !== 32'h4) $display("FAIL midframe_reset_status: got %h want 00000004", ReadData); else n_pass++;
    @(negedge clk);
    reset   = 1'b0;
    DataAdr = '0;
    lows    = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    n_checks++; if (lows !== 0) $display("FAIL midframe_line_quiet: got %0d low cycles want 0", lows); else n_pass++;
    n_checks++; if (frames_q.size() !== 0) $display("FAIL midframe_frames: got %0d want 0", frames_q.size()); else n_pass++;
  endtask

  task automatic test_addr_decode;
    frames_q.delete();
    write(BASE + 8, {24'h0, 8'($urandom)});
    DataAdr = BASE + 8;
    #1;
    n_checks++; if (rd_hit !== 1'b0) $display("FAIL addr_hit_plus8: got %b want 0", rd_hit); else n_pass++;
    n_checks++; if (ReadData !== 32'h0) $display("FAIL addr_read_plus8: got %h want 00000000", ReadData); else n_pass++;
    DataAdr = BASE;
    #1;
    n_checks++; if (rd_hit !== 1'b1) $display("FAIL addr_hit_data: got %b want 1", rd_hit); else n_pass++;
    n_checks++; if (ReadData !== 32'h0) $display("FAIL addr_read_data: got %h want 00000000", ReadData); else n_pass++;
    repeat (CPB) @(negedge clk);
    DataAdr = BASE + 4;
    #1;
    n_checks++; if (ReadData !== 32'h4) $display("FAIL addr_no_push: got %h want 00000004", ReadData); else n_pass++;
    n_checks++; if (frames_q.size() !== 0) $display("FAIL addr_no_frame: got %0d want 0", frames_q.size()); else n_pass++;
    DataAdr = '0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_random;
    test_overflow;
    test_reset_mid;
    test_addr_decode;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the processor's data-memory bus, downstream of the core alongside `dmem`. Consumes the core's store port (`MemWrite`, `DataAdr`, `WriteData`). Queues byte writes to its data register in a small FIFO and serialises them as 8N1 frames on `tx`. Exposes a readable status register so firmware can poll before writing.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_0400, byte address of the data register; the status register is at `BASE_ADDR+4`.
- `CLKS_PER_BIT`, 16, clock cycles per UART bit; legal range ≥2.
- `FIFO_DEPTH`, 4, entries in the TX FIFO; a power of two, ≥2.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `MemWrite`  in  1  store strobe from the core.
- `DataAdr`  in  32  store/load address from the core.
- `WriteData`  in  32  store data; only `[7:0]` (data reg) or `[3]` (status reg) is used.
- `ReadData`  out  32  combinational status readback.
- `rd_hit`  out  1  high when `DataAdr` is `BASE_ADDR` or `BASE_ADDR+4`; used by the top-level read mux.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  FIFO non-empty or frame in progress.

## Operation
- **Data write:** `MemWrite && DataAdr==BASE_ADDR` pushes `WriteData[7:0]`.
  - The push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and the sticky `overflow` flag is set.
- **Status write:** `MemWrite && DataAdr==BASE_ADDR+4` with `WriteData[3]=1` clears `overflow`.
  - A set and a clear in the same cycle cannot collide, because the two writes use different addresses.
- **Status read:** `ReadData = {28'b0, overflow, empty, full, busy}` when `DataAdr==BASE_ADDR+4`.
  - `ReadData` is 0 at any other address, including `BASE_ADDR`; the data register is write-only.
  - `ReadData` is purely combinational from `DataAdr` and the current state.
- **TX FSM** (states `IDLE`, `START`, `DATA`, `STOP`):
  - `IDLE`: `tx=1`. If the FIFO is non-empty, pop the head into an 8-bit shift register, clear the bit counter, go to `START`.
  - `START`: `tx=0` for `CLKS_PER_BIT` cycles, then go to `DATA`.
  - `DATA`: `tx=shift[0]`, LSB first. Each `CLKS_PER_BIT` cycles, shift right and increment the bit index. After bit 7 completes, go to `STOP`.
  - `STOP`: `tx=1` for `CLKS_PER_BIT` cycles, then go to `IDLE`.
- Baud counter: `$clog2(CLKS_PER_BIT)` bits. It counts 0..`CLKS_PER_BIT-1` and reloads to 0 on every state or bit change.
- `tx` is driven from a register (glitch-free).
- FIFO pointers wrap modulo `FIFO_DEPTH`. `full`/`empty` come from a `$clog2(FIFO_DEPTH)+1`-bit count.

## Timing
- Reset values: `tx=1`, `busy=0`, state `IDLE`, FIFO empty (`empty=1`, `full=0`), `overflow=0`. `ReadData` is then 32'h4 at the status address.
- Write-to-line latency: byte accepted at edge E0 → popped at E1 → `tx` low from E1.
- Frame length: exactly `10*CLKS_PER_BIT` cycles from the falling start edge to the end of the stop bit.
- Back-to-back frames: exactly one `IDLE` cycle with `tx=1` between a stop bit and the next start bit.
- Push in the same cycle as a pop while full: accepted, count unchanged, `overflow` not set.
- `busy` deasserts on the edge where `STOP` returns to `IDLE` with the FIFO empty.
- Reset mid-frame: at the next edge, `tx=1`, state `IDLE`, FIFO flushed, `overflow` cleared. The partial frame is abandoned.

## Structure
- Package `uart_pkg`:
  - `tx_state_t` enum (`IDLE`, `START`, `DATA`, `STOP`).
  - Register offsets `UART_DATA_OFS=0`, `UART_STAT_OFS=4`.
  - Status bit indices `ST_BUSY=0`, `ST_FULL=1`, `ST_EMPTY=2`, `ST_OVF=3`.
- Sub-module `sync_fifo` (parameters `WIDTH=8`, `DEPTH`):
  - Inputs: `push`, `pop`, `din`.
  - Outputs: `dout` (head, first-word-fall-through), `full`, `empty`.
  - Simultaneous push and pop are allowed.
  - `mmio_uart_tx` contains the address decode, status logic and TX FSM.

## Test plan
- **Reset:** hold `reset` 2 cycles → `tx=1`, `busy=0`, `ReadData=32'h4` at `BASE_ADDR+4`.
- **Single byte:** write 8'hA5 to `BASE_ADDR` (`CLKS_PER_BIT=16`) → `tx` low one cycle after the write edge. Sampled mid-bit, the line reads 0,1,0,1,0,0,1,0,1,1 over 160 cycles, then `busy=0`.
- **Back-to-back:** write 8'h01 then 8'h80 on consecutive cycles → two frames separated by exactly one high cycle. Total `busy` time is 321 cycles.
- **Overflow:** write 6 bytes on consecutive cycles with `FIFO_DEPTH=4`.
  - The first byte is popped and 4 are queued, so the 6th is dropped.
  - Status reads `overflow=1`, `full=1`.
  - Write 32'h8 to `BASE_ADDR+4` → `overflow=0`.
  - Exactly 5 frames are transmitted.
- **Reset mid-frame:** assert `reset` during `DATA` bit 3 with 2 bytes queued → `tx=1` next edge, `busy=0`, no further frames.
- **Address decode:** writes to `BASE_ADDR+8` and reads of `BASE_ADDR` → no push, `rd_hit=0` at `+8`, `ReadData=0` at `BASE_ADDR`.
